decode_stage: RTL and testbench

//  Consumer end of the fetch interface. Takes fetch's pc_out, valid flag and the

---
 rtl/cpu_isa_pkg.sv | 54 +++++
 rtl/decode_stage_if.sv | 37 +++
 rtl/instr_fields.sv | 28 ++
 rtl/decode_stage.sv | 107 ++++++++++
 tb/tb_decode_stage.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_isa_pkg.sv
// ISA constants, field positions and decode payload types shared by the
// fetch/decode front end.
package cpu_isa_pkg;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned REG_W   = 3;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned SIMM_W  = 7;
    localparam int unsigned IMM10_W = 10;

    localparam int unsigned OPC_LSB = 13;
    localparam int unsigned RA_LSB  = 10;
    localparam int unsigned RB_LSB  = 7;
    localparam int unsigned RC_LSB  = 0;

    typedef enum logic [OPC_W-1:0] {
        ADD  = 3'd0,
        ADDI = 3'd1,
        NAND = 3'd2,
        LUI  = 3'd3,
        SW   = 3'd4,
        LW   = 3'd5,
        BEQ  = 3'd6,
        JALR = 3'd7
    } opc_e;

    typedef struct packed {
        opc_e             opc;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [REG_W-1:0] rc;
        logic [IMM_W-1:0] imm;
        logic             use_ra;
        logic             use_rc;
    } fields_t;

    typedef struct packed {
        logic             valid;
        logic [PC_W-1:0]  pc;
        opc_e             opc;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [REG_W-1:0] rc;
        logic [IMM_W-1:0] imm;
        logic             pred_taken;
    } dec_bundle_t;

    function automatic logic [IMM_W-1:0] sext_simm7(input logic [SIMM_W-1:0] s);
        return {{(IMM_W-SIMM_W){s[SIMM_W-1]}}, s};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch <-> decode handshake plus the registered bundle handed to execute.
interface decode_stage_if;
    import cpu_isa_pkg::*;

    logic [PC_W-1:0]    f_pc;
    logic               f_valid;
    logic [INSTR_W-1:0] instr;
    logic               ex_redirect;
    logic [PC_W-1:0]    ex_tgt;

    logic               stall;
    logic               flush;
    logic               branch;
    logic [PC_W-1:0]    branch_tgt;

    logic               d_valid;
    logic [PC_W-1:0]    d_pc;
    logic [OPC_W-1:0]   d_opc;
    logic [REG_W-1:0]   d_ra;
    logic [REG_W-1:0]   d_rb;
    logic [REG_W-1:0]   d_rc;
    logic [IMM_W-1:0]   d_imm;
    logic               d_pred_taken;

    modport master (
        output f_pc, f_valid, instr, ex_redirect, ex_tgt,
        input  stall, flush, branch, branch_tgt,
        input  d_valid, d_pc, d_opc, d_ra, d_rb, d_rc, d_imm, d_pred_taken
    );

    modport slave (
        input  f_pc, f_valid, instr, ex_redirect, ex_tgt,
        output stall, flush, branch, branch_tgt,
        output d_valid, d_pc, d_opc, d_ra, d_rb, d_rc, d_imm, d_pred_taken
    );

endinterface

// File: rtl/instr_fields.sv
// Combinational split of an instruction word into fields, immediate and
// the register-read flags used by the hazard check.
module instr_fields
    import cpu_isa_pkg::*;
(
    input  logic [INSTR_W-1:0] i_word,
    output fields_t            o_fields
);

    opc_e w_opc;

    assign w_opc = opc_e'(i_word[OPC_LSB +: OPC_W]);

    always_comb begin
        o_fields        = '0;
        o_fields.opc    = w_opc;
        o_fields.ra     = i_word[RA_LSB +: REG_W];
        o_fields.rb     = i_word[RB_LSB +: REG_W];
        o_fields.rc     = i_word[RC_LSB +: REG_W];
        // lui carries a 10-bit upper immediate; everything else a signed 7-bit one
        o_fields.imm    = (w_opc == LUI)
                        ? {i_word[IMM10_W-1:0], {(IMM_W-IMM10_W){1'b0}}}
                        : sext_simm7(i_word[SIMM_W-1:0]);
        o_fields.use_rc = (w_opc == ADD) || (w_opc == NAND);
        o_fields.use_ra = (w_opc == SW)  || (w_opc == BEQ);
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: load-use interlock, static backward-taken beq prediction,
// execute redirect handling and the registered bundle for execute.
module decode_stage
    import cpu_isa_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  bus
);

    logic               r_hold_valid;
    logic [INSTR_W-1:0] r_instr_hold;
    dec_bundle_t        r_d;

    logic               w_hold_valid_nxt;
    logic [INSTR_W-1:0] w_instr_hold_nxt;
    dec_bundle_t        w_d_nxt;
    logic [INSTR_W-1:0] w_cur;
    fields_t            w_f;
    logic               w_src_hit;
    logic               w_load_use;
    logic               w_pred;
    logic [PC_W-1:0]    w_pred_tgt;
    logic               w_stall;
    logic               w_flush;
    logic               w_branch;
    logic [PC_W-1:0]    w_branch_tgt;

    // the word captured during a stall replaces the (re-read) memory output once
    assign w_cur = r_hold_valid ? r_instr_hold : bus.instr;

    instr_fields u_fields (
        .i_word   (w_cur),
        .o_fields (w_f)
    );

    assign w_src_hit  = (w_f.rb == r_d.ra)
                      | (w_f.use_rc & (w_f.rc == r_d.ra))
                      | (w_f.use_ra & (w_f.ra == r_d.ra));
    assign w_load_use = r_d.valid & (r_d.opc == LW) & (r_d.ra != '0)
                      & bus.f_valid & w_src_hit;
    assign w_pred     = bus.f_valid & (w_f.opc == BEQ) & w_f.imm[IMM_W-1];
    assign w_pred_tgt = bus.f_pc + PC_W'(1) + PC_W'(w_f.imm);

    // priority: execute redirect, then load-use stall, then predicted beq
    always_comb begin
        w_stall          = 1'b0;
        w_flush          = 1'b0;
        w_branch         = 1'b0;
        w_branch_tgt     = '0;
        w_d_nxt          = r_d;
        w_hold_valid_nxt = 1'b0;
        w_instr_hold_nxt = r_instr_hold;

        if (bus.ex_redirect) begin
            w_branch      = 1'b1;
            w_flush       = 1'b1;
            w_branch_tgt  = bus.ex_tgt;
            w_d_nxt.valid = 1'b0;
        end else if (w_load_use) begin
            w_stall          = 1'b1;
            w_d_nxt.valid    = 1'b0;
            w_hold_valid_nxt = 1'b1;
            w_instr_hold_nxt = bus.instr;
        end else begin
            w_d_nxt.valid      = bus.f_valid;
            w_d_nxt.pc         = bus.f_pc;
            w_d_nxt.opc        = w_f.opc;
            w_d_nxt.ra         = w_f.ra;
            w_d_nxt.rb         = w_f.rb;
            w_d_nxt.rc         = w_f.rc;
            w_d_nxt.imm        = w_f.imm;
            w_d_nxt.pred_taken = w_pred;
            if (w_pred) begin
                w_branch     = 1'b1;
                w_flush      = 1'b1;
                w_branch_tgt = w_pred_tgt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d          <= '0;
            r_hold_valid <= 1'b0;
            r_instr_hold <= '0;
        end else begin
            r_d          <= w_d_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_instr_hold <= w_instr_hold_nxt;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.flush        = w_flush;
    assign bus.branch       = w_branch;
    assign bus.branch_tgt   = w_branch_tgt;
    assign bus.d_valid      = r_d.valid;
    assign bus.d_pc         = r_d.pc;
    assign bus.d_opc        = r_d.opc;
    assign bus.d_ra         = r_d.ra;
    assign bus.d_rb         = r_d.rb;
    assign bus.d_rc         = r_d.rc;
    assign bus.d_imm        = r_d.imm;
    assign bus.d_pred_taken = r_d.pred_taken;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, async reset mid-stall,
// then random traffic against a queue-based reference model.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] pc, input logic v, input logic [15:0] ins,
                         input logic rd, input logic [15:0] xt);
        bus.f_pc        = pc;
        bus.f_valid     = v;
        bus.instr       = ins;
        bus.ex_redirect = rd;
        bus.ex_tgt      = xt;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [15:0] pc;
        logic        v;
        logic [15:0] ins;
        logic        rd;
        logic [15:0] xt;
        logic        stall;
        logic        flush;
        logic        branch;
        logic [15:0] tgt;
        logic        dv;
        logic [2:0]  opc;
        logic [2:0]  rc;
        logic        pred;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] pc, input logic v, input logic [15:0] ins,
                                input logic rd, input logic [15:0] xt,
                                input logic st, input logic fl, input logic br,
                                input logic [15:0] tg, input logic dv,
                                input logic [2:0] op, input logic [2:0] rc, input logic pr);
        vec_t r;
        r.pc = pc; r.v = v; r.ins = ins; r.rd = rd; r.xt = xt;
        r.stall = st; r.flush = fl; r.branch = br; r.tgt = tg;
        r.dv = dv; r.opc = op; r.rc = rc; r.pred = pr;
        return r;
    endfunction

    vec_t vecs[14];

    // ---------------- reference model ----------------
    logic        m_valid;
    logic [15:0] m_pc;
    logic [2:0]  m_opc, m_ra, m_rb, m_rc;
    logic [15:0] m_imm;
    logic        m_pred;
    logic [15:0] pend[$];

    // set of registers an instruction reads, one bit per register
    function automatic logic [7:0] reads(input logic [15:0] w);
        logic [7:0] m;
        logic [2:0] op;
        op = w[15:13];
        m  = 8'b1 << w[9:7];
        if (op == 3'd0 || op == 3'd2) m = m | (8'b1 << w[2:0]);
        if (op == 3'd4 || op == 3'd6) m = m | (8'b1 << w[12:10]);
        return m;
    endfunction

    function automatic int simm(input logic [15:0] w);
        int s;
        s = int'(w) & 127;
        if (s >= 64) s = s - 128;
        return s;
    endfunction

    function automatic logic [15:0] imm_of(input logic [15:0] w);
        if (w[15:13] == 3'd3) return 16'((int'(w) & 1023) * 64);
        return 16'(simm(w));
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_pc = '0; m_opc = '0; m_ra = '0; m_rb = '0; m_rc = '0;
        m_imm = '0; m_pred = 1'b0;
        pend.delete();
    endtask

    task automatic rnd_cycle(input int idx, input logic [15:0] pc, input logic v,
                             input logic [15:0] ins, input logic rd, input logic [15:0] xt);
        logic [15:0] cur;
        logic [7:0]  rmask;
        logic        lu, pr;
        logic        e_st, e_fl, e_br;
        logic [15:0] e_tg;
        drive(pc, v, ins, rd, xt);
        cur   = (pend.size() != 0) ? pend[0] : ins;
        rmask = reads(cur);
        lu    = m_valid && (m_opc == 3'd5) && (m_ra != 3'd0) && v && rmask[m_ra];
        pr    = v && (cur[15:13] == 3'd6) && cur[6];
        e_st = 1'b0; e_fl = 1'b0; e_br = 1'b0; e_tg = '0;
        if (rd) begin
            e_fl = 1'b1; e_br = 1'b1; e_tg = xt;
        end else if (lu) begin
            e_st = 1'b1;
        end else if (pr) begin
            e_fl = 1'b1; e_br = 1'b1; e_tg = 16'(int'(pc) + 1 + simm(cur));
        end
        @(negedge clk);
        check("rnd stall",  idx, 32'(bus.stall),  32'(e_st));
        check("rnd flush",  idx, 32'(bus.flush),  32'(e_fl));
        check("rnd branch", idx, 32'(bus.branch), 32'(e_br));
        if (e_br) check("rnd branch_tgt", idx, 32'(bus.branch_tgt), 32'(e_tg));
        @(posedge clk);
        #1;
        if (rd) begin
            m_valid = 1'b0;
            pend.delete();
        end else if (lu) begin
            m_valid = 1'b0;
            pend.delete();
            pend.push_back(ins);
        end else begin
            m_valid = v;     m_pc  = pc;
            m_opc = cur[15:13]; m_ra = cur[12:10]; m_rb = cur[9:7]; m_rc = cur[2:0];
            m_imm = imm_of(cur); m_pred = pr;
            pend.delete();
        end
        check("rnd d_valid", idx, 32'(bus.d_valid), 32'(m_valid));
        if (m_valid) begin
            check("rnd d_pc",   idx, 32'(bus.d_pc),   32'(m_pc));
            check("rnd d_opc",  idx, 32'(bus.d_opc),  32'(m_opc));
            check("rnd d_ra",   idx, 32'(bus.d_ra),   32'(m_ra));
            check("rnd d_rb",   idx, 32'(bus.d_rb),   32'(m_rb));
            check("rnd d_rc",   idx, 32'(bus.d_rc),   32'(m_rc));
            check("rnd d_imm",  idx, 32'(bus.d_imm),  32'(m_imm));
            check("rnd d_pred", idx, 32'(bus.d_pred_taken), 32'(m_pred));
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        drive(16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        #12;
        check("reset d_valid", 0, 32'(bus.d_valid), 32'd0);
        check("reset d_pc",    0, 32'(bus.d_pc),    32'd0);
        check("reset d_imm",   0, 32'(bus.d_imm),   32'd0);
        check("reset stall",   0, 32'(bus.stall),   32'd0);
        check("reset branch",  0, 32'(bus.branch),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //             pc       v  instr     rd xt       st fl br tgt      dv opc   rc    pr
        vecs[0]  = mk(16'h0010, 1, 16'hAC00, 0, 16'h0,   0, 0, 0, 16'h0,   1, 3'd5, 3'd0, 0); // lw r3
        vecs[1]  = mk(16'h0011, 1, 16'h0503, 0, 16'h0,   1, 0, 0, 16'h0,   0, 3'd0, 3'd0, 0); // add r1,r2,r3 stalls
        vecs[2]  = mk(16'h0011, 1, 16'hFFFF, 0, 16'h0,   0, 0, 0, 16'h0,   1, 3'd0, 3'd3, 0); // issues from hold
        vecs[3]  = mk(16'h0012, 1, 16'hA080, 0, 16'h0,   0, 0, 0, 16'h0,   1, 3'd5, 3'd0, 0); // lw r0
        vecs[4]  = mk(16'h0013, 1, 16'h0400, 0, 16'h0,   0, 0, 0, 16'h0,   1, 3'd0, 3'd0, 0); // uses r0: no stall
        vecs[5]  = mk(16'h0014, 1, 16'hAC00, 0, 16'h0,   0, 0, 0, 16'h0,   1, 3'd5, 3'd0, 0); // lw r3
        vecs[6]  = mk(16'h0015, 0, 16'h0503, 0, 16'h0,   0, 0, 0, 16'h0,   0, 3'd0, 3'd0, 0); // bubble gap
        vecs[7]  = mk(16'h0016, 1, 16'h0503, 0, 16'h0,   0, 0, 0, 16'h0,   1, 3'd0, 3'd3, 0); // no stall after gap
        vecs[8]  = mk(16'h0010, 1, 16'hC07E, 0, 16'h0,   0, 1, 1, 16'h000F, 1, 3'd6, 3'd6, 1); // beq -2
        vecs[9]  = mk(16'h0020, 1, 16'hC003, 0, 16'h0,   0, 0, 0, 16'h0,   1, 3'd6, 3'd3, 0); // beq +3
        vecs[10] = mk(16'h0030, 1, 16'hAC00, 0, 16'h0,   0, 0, 0, 16'h0,   1, 3'd5, 3'd0, 0); // lw r3
        vecs[11] = mk(16'h0031, 1, 16'h0503, 1, 16'h1234, 0, 1, 1, 16'h1234, 0, 3'd0, 3'd0, 0); // redirect wins
        vecs[12] = mk(16'hFFFF, 1, 16'hC07F, 0, 16'h0,   0, 1, 1, 16'hFFFF, 1, 3'd6, 3'd7, 1); // wrap
        vecs[13] = mk(16'h0010, 0, 16'hC07E, 0, 16'h0,   0, 0, 0, 16'h0,   0, 3'd0, 3'd0, 0); // invalid beq

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].pc, vecs[i].v, vecs[i].ins, vecs[i].rd, vecs[i].xt);
            @(negedge clk);
            check("stall",  i, 32'(bus.stall),  32'(vecs[i].stall));
            check("flush",  i, 32'(bus.flush),  32'(vecs[i].flush));
            check("branch", i, 32'(bus.branch), 32'(vecs[i].branch));
            if (vecs[i].branch) check("branch_tgt", i, 32'(bus.branch_tgt), 32'(vecs[i].tgt));
            @(posedge clk);
            #1;
            check("d_valid", i, 32'(bus.d_valid), 32'(vecs[i].dv));
            if (vecs[i].dv) begin
                check("d_opc",  i, 32'(bus.d_opc),        32'(vecs[i].opc));
                check("d_rc",   i, 32'(bus.d_rc),         32'(vecs[i].rc));
                check("d_pred", i, 32'(bus.d_pred_taken), 32'(vecs[i].pred));
            end
        end

        // async reset in the middle of a stall drops the held word
        drive(16'h0040, 1'b1, 16'hAC00, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        drive(16'h0041, 1'b1, 16'h0503, 1'b0, 16'h0);
        #2;
        check("midstall stall", 0, 32'(bus.stall), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async d_valid", 0, 32'(bus.d_valid), 32'd0);
        check("async d_opc",   0, 32'(bus.d_opc),   32'd0);
        check("async d_pc",    0, 32'(bus.d_pc),    32'd0);
        check("async d_rc",    0, 32'(bus.d_rc),    32'd0);
        check("async stall",   0, 32'(bus.stall),   32'd0);
        check("async flush",   0, 32'(bus.flush),   32'd0);
        check("async branch",  0, 32'(bus.branch),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h0050, 1'b1, 16'h0400, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        check("post-reset d_valid", 0, 32'(bus.d_valid), 32'd1);
        check("post-reset d_pc",    0, 32'(bus.d_pc),    32'h0050);
        check("post-reset d_rc",    0, 32'(bus.d_rc),    32'd0);
        check("post-reset d_ra",    0, 32'(bus.d_ra),    32'd1);

        // random traffic against the reference model
        reset_pulse();
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] pc, ins;
            logic        v, rd;
            logic [2:0]  op, ra, rb, rc;
            op  = 3'($urandom_range(0, 7));
            ra  = 3'($urandom_range(0, 3));
            rb  = 3'($urandom_range(0, 3));
            rc  = 3'($urandom_range(0, 3));
            ins = {op, ra, rb, 4'($urandom_range(0, 15)), rc};
            v   = ($urandom_range(0, 9) < 8);
            rd  = ($urandom_range(0, 19) == 0);
            pc  = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
            rnd_cycle(i, pc, v, ins, rd, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
